// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm controller slice.
// Time-field widths follow the upstream 24-hour clock counter.
package alarm_pkg;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   localparam logic [HOUR_W-1:0] MAX_HOUR = 5'd23;
   localparam logic [MIN_W-1:0]  MAX_MIN  = 6'd59;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RINGING = 2'd1,
      SNOOZE  = 2'd2
   } state_t;

   // True when a requested alarm time is a legal hh:mm value
   function automatic logic set_valid(input logic [HOUR_W-1:0] h,
                                      input logic [MIN_W-1:0]  m);
      return (h <= MAX_HOUR) && (m <= MAX_MIN);
   endfunction

endpackage

// File: rtl/sec_down_counter.sv
// Loadable down counter advanced by the 1 s tick.
// zero pulses combinationally on the tick that moves the count from 1 to 0.
module sec_down_counter #(
   parameter int W = 9
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   input  logic         tick,
   output logic         zero
);

   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] NIL = {W{1'b0}};

   logic [W-1:0] count_r;

   // Load has priority over decrement; the count parks at zero
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count_r <= NIL;
      end else if (load) begin
         count_r <= load_val;
      end else if (en && tick && (count_r != NIL)) begin
         count_r <= count_r - ONE;
      end else begin
         count_r <= count_r;
      end
   end

   assign zero = en && tick && !load && (count_r == ONE);

endmodule

// File: rtl/alarm_controller.sv
// Alarm time register plus ring/snooze state machine driving the buzzer.
// Ring and snooze intervals are counted in seconds from sec_tick.
module alarm_controller
   import alarm_pkg::*;
#(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300,
   parameter int MAX_SNOOZES = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sec_tick,
   input  logic [HOUR_W-1:0] hours,
   input  logic [MIN_W-1:0]  minutes,
   input  logic [SEC_W-1:0]  seconds,
   input  logic              set_en,
   input  logic [HOUR_W-1:0] set_hours,
   input  logic [MIN_W-1:0]  set_minutes,
   input  logic              arm,
   input  logic              snooze,
   input  logic              stop,
   output logic [HOUR_W-1:0] alarm_h,
   output logic [MIN_W-1:0]  alarm_m,
   output logic              buzzer,
   output logic              ringing,
   output logic              snoozing
);

   localparam int TMR_MAX = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam int CNT_W   = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1;

   localparam logic [TMR_W-1:0] RING_LOAD   = TMR_W'(RING_SECS);
   localparam logic [TMR_W-1:0] SNOOZE_LOAD = TMR_W'(SNOOZE_SECS);
   localparam logic [CNT_W-1:0] SNZ_LIMIT   = CNT_W'(MAX_SNOOZES);
   localparam logic [CNT_W-1:0] SNZ_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_r;
   state_t           next_state_s;
   logic             match_q_r;
   logic [CNT_W-1:0] snz_cnt_r;
   logic             match_s;
   logic             trigger_s;
   logic             ring_load_s;
   logic             snooze_load_s;
   logic             ring_zero_s;
   logic             snooze_zero_s;

   assign match_s   = arm && (hours == alarm_h) && (minutes == alarm_m) &&
                      (seconds == 6'd0);
   assign trigger_s = match_s && !match_q_r;

   sec_down_counter #(.W(TMR_W)) u_ring_tmr (
      .clk      (clk),
      .rst      (rst),
      .load     (ring_load_s),
      .load_val (RING_LOAD),
      .en       (state_r == RINGING),
      .tick     (sec_tick),
      .zero     (ring_zero_s)
   );

   sec_down_counter #(.W(TMR_W)) u_snooze_tmr (
      .clk      (clk),
      .rst      (rst),
      .load     (snooze_load_s),
      .load_val (SNOOZE_LOAD),
      .en       (state_r == SNOOZE),
      .tick     (sec_tick),
      .zero     (snooze_zero_s)
   );

   // Next-state decode; priority arm=0 > stop > snooze > timer expiry > trigger
   always_comb begin
      next_state_s  = state_r;
      ring_load_s   = 1'b0;
      snooze_load_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (trigger_s && !stop) begin
               next_state_s = RINGING;
               ring_load_s  = 1'b1;
            end else begin
               next_state_s = IDLE;
            end
         end
         RINGING: begin
            if (!arm || stop) begin
               next_state_s = IDLE;
            end else if (snooze) begin
               if (snz_cnt_r < SNZ_LIMIT) begin
                  next_state_s  = SNOOZE;
                  snooze_load_s = 1'b1;
               end else begin
                  next_state_s = IDLE;
               end
            end else if (ring_zero_s) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = RINGING;
            end
         end
         SNOOZE: begin
            if (!arm || stop) begin
               next_state_s = IDLE;
            end else if (snooze_zero_s) begin
               next_state_s = RINGING;
               ring_load_s  = 1'b1;
            end else begin
               next_state_s = SNOOZE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // State, snooze count, alarm register and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r   <= IDLE;
         match_q_r <= 1'b0;
         snz_cnt_r <= {CNT_W{1'b0}};
         alarm_h   <= 5'd6;
         alarm_m   <= 6'd0;
         buzzer    <= 1'b0;
         ringing   <= 1'b0;
         snoozing  <= 1'b0;
      end else begin
         state_r   <= next_state_s;
         match_q_r <= match_s;
         ringing   <= (next_state_s == RINGING);
         snoozing  <= (next_state_s == SNOOZE);

         if (set_en && set_valid(set_hours, set_minutes)) begin
            alarm_h <= set_hours;
            alarm_m <= set_minutes;
         end else begin
            alarm_h <= alarm_h;
            alarm_m <= alarm_m;
         end

         if ((state_r == IDLE) && (next_state_s == RINGING)) begin
            snz_cnt_r <= {CNT_W{1'b0}};
         end else if (snooze_load_s) begin
            snz_cnt_r <= snz_cnt_r + SNZ_ONE;
         end else begin
            snz_cnt_r <= snz_cnt_r;
         end

         // Buzzer starts high on each entry to RINGING, then toggles per second
         if (next_state_s != RINGING) begin
            buzzer <= 1'b0;
         end else if (state_r != RINGING) begin
            buzzer <= 1'b1;
         end else if (sec_tick) begin
            buzzer <= ~buzzer;
         end else begin
            buzzer <= buzzer;
         end
      end
   end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed testbench for alarm_controller with default parameters.
module tb_alarm_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       sec_tick = 1'b0;
   logic [4:0] hours = 5'd0;
   logic [5:0] minutes = 6'd0;
   logic [5:0] seconds = 6'd0;
   logic       set_en = 1'b0;
   logic [4:0] set_hours = 5'd0;
   logic [5:0] set_minutes = 6'd0;
   logic       arm = 1'b0;
   logic       snooze = 1'b0;
   logic       stop = 1'b0;
   logic [4:0] alarm_h;
   logic [5:0] alarm_m;
   logic       buzzer;
   logic       ringing;
   logic       snoozing;

   int errors = 0;
   int checks = 0;

   alarm_controller dut (
      .clk         (clk),
      .rst         (rst),
      .sec_tick    (sec_tick),
      .hours       (hours),
      .minutes     (minutes),
      .seconds     (seconds),
      .set_en      (set_en),
      .set_hours   (set_hours),
      .set_minutes (set_minutes),
      .arm         (arm),
      .snooze      (snooze),
      .stop        (stop),
      .alarm_h     (alarm_h),
      .alarm_m     (alarm_m),
      .buzzer      (buzzer),
      .ringing     (ringing),
      .snoozing    (snoozing)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      sec_tick = 1'b1;
      repeat (n) cyc();
      sec_tick = 1'b0;
   endtask

   task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
      hours = h;
      minutes = m;
      seconds = s;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic load_alarm(input logic [4:0] h, input logic [5:0] m);
      set_en = 1'b1;
      set_hours = h;
      set_minutes = m;
      cyc();
      set_en = 1'b0;
   endtask

   initial begin
      // Reset values
      cyc();
      cyc();
      chk("rst_alarm_h", alarm_h, 6);
      chk("rst_alarm_m", alarm_m, 0);
      chk("rst_buzzer", buzzer, 0);
      chk("rst_ringing", ringing, 0);
      chk("rst_snoozing", snoozing, 0);
      rst = 1'b1;
      cyc();

      // Program 07:30 and trigger on the minute
      load_alarm(5'd7, 6'd30);
      chk("set_h_0730", alarm_h, 7);
      chk("set_m_0730", alarm_m, 30);
      arm = 1'b1;
      set_time(5'd7, 6'd29, 6'd59);
      cyc();
      chk("pre_match_ringing", ringing, 0);
      set_time(5'd7, 6'd30, 6'd0);
      sec_tick = 1'b1;
      cyc();
      sec_tick = 1'b0;
      chk("trig_ringing", ringing, 1);
      chk("trig_buzzer", buzzer, 1);
      set_time(5'd7, 6'd30, 6'd1);
      tick_n(1);
      chk("tick1_buzzer", buzzer, 0);
      tick_n(1);
      chk("tick2_buzzer", buzzer, 1);
      tick_n(57);
      chk("tick59_ringing", ringing, 1);
      tick_n(1);
      chk("tick60_ringing", ringing, 0);
      chk("tick60_buzzer", buzzer, 0);

      // Snooze three times, fourth press stops
      set_time(5'd7, 6'd29, 6'd59);
      cyc();
      set_time(5'd7, 6'd30, 6'd0);
      cyc();
      chk("snz_trig_ringing", ringing, 1);
      set_time(5'd7, 6'd30, 6'd5);
      for (int i = 0; i < 3; i++) begin
         snooze = 1'b1;
         cyc();
         snooze = 1'b0;
         chk("snz_snoozing", snoozing, 1);
         chk("snz_buzzer", buzzer, 0);
         tick_n(299);
         chk("snz299_snoozing", snoozing, 1);
         tick_n(1);
         chk("snz300_ringing", ringing, 1);
         chk("snz300_buzzer", buzzer, 1);
      end
      snooze = 1'b1;
      cyc();
      snooze = 1'b0;
      chk("snz4_ringing", ringing, 0);
      chk("snz4_snoozing", snoozing, 0);

      // Stop inside the matching second must not retrigger
      set_time(5'd7, 6'd29, 6'd59);
      cyc();
      set_time(5'd7, 6'd30, 6'd0);
      cyc();
      chk("stop_trig_ringing", ringing, 1);
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      chk("stop_ringing", ringing, 0);
      cyc();
      cyc();
      chk("stop_hold_ringing", ringing, 0);
      set_time(5'd7, 6'd30, 6'd1);
      cyc();
      set_time(5'd7, 6'd29, 6'd59);
      cyc();
      set_time(5'd7, 6'd30, 6'd0);
      cyc();
      chk("nextday_ringing", ringing, 1);
      stop = 1'b1;
      cyc();
      stop = 1'b0;

      // Out-of-range set values are ignored, 23:59 is accepted
      load_alarm(5'd24, 6'd10);
      chk("bad_h_alarm_h", alarm_h, 7);
      chk("bad_h_alarm_m", alarm_m, 30);
      load_alarm(5'd12, 6'd60);
      chk("bad_m_alarm_h", alarm_h, 7);
      chk("bad_m_alarm_m", alarm_m, 30);
      load_alarm(5'd23, 6'd59);
      chk("set_h_2359", alarm_h, 23);
      chk("set_m_2359", alarm_m, 59);
      set_time(5'd23, 6'd58, 6'd59);
      cyc();
      set_time(5'd23, 6'd59, 6'd0);
      cyc();
      chk("t2359_ringing", ringing, 1);

      // Stop and snooze together go to IDLE
      set_time(5'd23, 6'd59, 6'd1);
      stop = 1'b1;
      snooze = 1'b1;
      cyc();
      stop = 1'b0;
      snooze = 1'b0;
      chk("stopsnz_ringing", ringing, 0);
      chk("stopsnz_snoozing", snoozing, 0);

      // Dropping arm during snooze cancels the event
      set_time(5'd23, 6'd58, 6'd59);
      cyc();
      set_time(5'd23, 6'd59, 6'd0);
      cyc();
      set_time(5'd23, 6'd59, 6'd5);
      snooze = 1'b1;
      cyc();
      snooze = 1'b0;
      chk("disarm_pre_snoozing", snoozing, 1);
      arm = 1'b0;
      cyc();
      chk("disarm_snoozing", snoozing, 0);
      chk("disarm_ringing", ringing, 0);
      arm = 1'b1;
      set_time(5'd23, 6'd59, 6'd10);
      tick_n(300);
      chk("disarm_no_rering", ringing, 0);

      // Asynchronous reset while ringing
      set_time(5'd23, 6'd58, 6'd59);
      cyc();
      set_time(5'd23, 6'd59, 6'd0);
      cyc();
      chk("prerst_ringing", ringing, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("midrst_ringing", ringing, 0);
      chk("midrst_buzzer", buzzer, 0);
      chk("midrst_snoozing", snoozing, 0);
      chk("midrst_alarm_h", alarm_h, 6);
      chk("midrst_alarm_m", alarm_m, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
